// File: rtl/secuenciador_contador.sv
// secuenciador_contador: drives the 4-bit contador through a parallel load plus a counted run,
// then reports the final count, steps executed and an illegal-command flag with a DONE pulse.
module secuenciador_contador (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] CMD_MODO,
    input  logic [3:0] CMD_VALOR,
    input  logic [3:0] CMD_PASOS,
    input  logic       CMD_PARAR_RCO,
    input  logic [3:0] Q,
    input  logic       RCO,
    output logic       ENB,
    output logic [1:0] MODO,
    output logic [3:0] D,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [3:0] RESULTADO,
    output logic [3:0] PASOS_HECHOS
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t     state_q, state_d;
    logic [1:0] modo_q, modo_d;
    logic [3:0] valor_q, valor_d;
    logic [3:0] pasos_q, pasos_d;
    logic [3:0] step_q, step_d;
    logic [3:0] res_q, res_d;
    logic [3:0] hechos_q, hechos_d;
    logic       parar_q, parar_d;
    logic       err_q, err_d;
    logic       error_q, error_d;
    logic       done_q, done_d;
    logic       stop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            modo_q   <= 2'b00;
            valor_q  <= 4'd0;
            pasos_q  <= 4'd0;
            step_q   <= 4'd0;
            res_q    <= 4'd0;
            hechos_q <= 4'd0;
            parar_q  <= 1'b0;
            err_q    <= 1'b0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            modo_q   <= modo_d;
            valor_q  <= valor_d;
            pasos_q  <= pasos_d;
            step_q   <= step_d;
            res_q    <= res_d;
            hechos_q <= hechos_d;
            parar_q  <= parar_d;
            err_q    <= err_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    // step_q is still zero in the first RUN cycle, where RCO only reflects the load
    assign stop = parar_q && RCO && (step_q != 4'd0);

    always_comb begin
        state_d  = state_q;
        modo_d   = modo_q;
        valor_d  = valor_q;
        pasos_d  = pasos_q;
        step_d   = step_q;
        res_d    = res_q;
        hechos_d = hechos_q;
        parar_d  = parar_q;
        err_d    = err_q;
        error_d  = error_q;
        done_d   = 1'b0;
        ENB      = 1'b0;
        MODO     = 2'b00;
        D        = 4'd0;
        case (state_q)
            IDLE: if (START) begin
                modo_d  = CMD_MODO;
                valor_d = CMD_VALOR;
                pasos_d = CMD_PASOS;
                parar_d = CMD_PARAR_RCO;
                step_d  = 4'd0;
                err_d   = CMD_MODO == 2'b11;
                state_d = (CMD_MODO == 2'b11) ? FIN : LOAD;
            end
            LOAD: begin
                ENB     = 1'b1;
                MODO    = 2'b11;
                D       = valor_q;
                state_d = (pasos_q != 4'd0) ? RUN : FIN;
            end
            RUN: begin
                MODO    = modo_q;
                ENB     = !stop;
                step_d  = stop ? step_q : step_q + 4'd1;
                state_d = (stop || step_q + 4'd1 == pasos_q) ? FIN : RUN;
            end
            FIN: begin
                res_d    = err_q ? res_q : Q;
                hechos_d = step_q;
                error_d  = err_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSY         = state_q != IDLE;
    assign DONE         = done_q;
    assign ERROR        = error_q;
    assign RESULTADO    = res_q;
    assign PASOS_HECHOS = hechos_q;
endmodule

// File: tb/tb_secuenciador_contador.sv
// tb_secuenciador_contador: drives the sequencer against a behavioural contador and checks
// every command against a loop-level reference of the load/run/early-stop rules.
module tb_secuenciador_contador;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [1:0] CMD_MODO = 2'b00;
    logic [3:0] CMD_VALOR = 4'd0;
    logic [3:0] CMD_PASOS = 4'd0;
    logic       CMD_PARAR_RCO = 1'b0;
    logic [3:0] Q = 4'd0;
    logic       RCO = 1'b0;
    logic       ENB, BUSY, DONE, ERROR;
    logic [1:0] MODO;
    logic [3:0] D, RESULTADO, PASOS_HECHOS;
    int         total = 0;
    int         bad = 0;
    logic [3:0] res_exp = 4'd0;

    secuenciador_contador dut (
        .CLK(CLK), .RESET(RESET), .START(START), .CMD_MODO(CMD_MODO),
        .CMD_VALOR(CMD_VALOR), .CMD_PASOS(CMD_PASOS), .CMD_PARAR_RCO(CMD_PARAR_RCO),
        .Q(Q), .RCO(RCO), .ENB(ENB), .MODO(MODO), .D(D), .BUSY(BUSY), .DONE(DONE),
        .ERROR(ERROR), .RESULTADO(RESULTADO), .PASOS_HECHOS(PASOS_HECHOS)
    );

    always #5 CLK = ~CLK;

    // contador stand-in: registered Q, RCO set on load and on wrap/borrow, holds when disabled
    always @(posedge CLK) begin
        if (ENB) begin
            case (MODO)
                2'b11: begin Q <= D; RCO <= 1'b1; end
                2'b00: begin RCO <= Q == 4'd15; Q <= Q + 4'd1; end
                2'b01: begin RCO <= Q == 4'd0; Q <= Q - 4'd1; end
                default: begin RCO <= Q < 4'd3; Q <= Q - 4'd3; end
            endcase
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Expected outcome of one command, counted in cycles after the START cycle
    task automatic ref_model(input logic [1:0] m, input logic [3:0] v, input logic [3:0] p,
                             input logic s, input logic [3:0] prev, output int lat, output int k,
                             output logic [3:0] r, output logic e, output int enbs);
        logic [3:0] q;
        logic       c;
        int         stopped;
        k = 0;
        stopped = 0;
        if (m == 2'b11) begin
            lat = 2; r = prev; e = 1'b1; enbs = 0;
            return;
        end
        q = v;
        c = 1'b1;
        for (int i = 0; i < int'(p); i++) begin
            if (s && c && i > 0) begin
                stopped = 1;
                break;
            end
            case (m)
                2'b00: begin c = q == 4'd15; q = q + 4'd1; end
                2'b01: begin c = q == 4'd0; q = q - 4'd1; end
                default: begin c = q < 4'd3; q = q - 4'd3; end
            endcase
            k++;
        end
        r = q;
        e = 1'b0;
        lat = k + 3 + stopped;
        enbs = 1 + k;
    endtask

    // Issues START in the current cycle and returns in the DONE cycle (lat=-1 on timeout)
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] v, input logic [3:0] p,
                           input logic s, output int lat, output int enbs, output int busys);
        CMD_MODO = m;
        CMD_VALOR = v;
        CMD_PASOS = p;
        CMD_PARAR_RCO = s;
        START = 1'b1;
        lat = -1;
        enbs = 0;
        busys = 0;
        tick();
        START = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (DONE) begin
                lat = c;
                break;
            end
            enbs += int'(ENB);
            busys += int'(BUSY);
            tick();
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick();
        tick();
        total++;
        if ({BUSY, DONE, ERROR, ENB, MODO, D, RESULTADO, PASOS_HECHOS} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {BUSY, DONE, ERROR, ENB, MODO, D, RESULTADO, PASOS_HECHOS});
        end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_directed;
        logic [1:0] tm [6] = '{2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
        logic [3:0] tv [6] = '{4'd3, 4'd9, 4'd13, 4'd5, 4'd0, 4'd10};
        logic [3:0] tp [6] = '{4'd4, 4'd2, 4'd8, 4'd6, 4'd1, 4'd0};
        logic       ts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int         el [6] = '{7, 5, 7, 2, 4, 3};
        logic [3:0] er [6] = '{4'd7, 4'd3, 4'd0, 4'd0, 4'd15, 4'd10};
        logic [3:0] ek [6] = '{4'd4, 4'd2, 4'd3, 4'd0, 4'd1, 4'd0};
        logic       ee [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int         en [6] = '{5, 3, 4, 0, 2, 1};
        int         lat, enbs, busys;
        for (int i = 0; i < 6; i++) begin
            run_cmd(tm[i], tv[i], tp[i], ts[i], lat, enbs, busys);
            total += 6;
            if (lat !== el[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, el[i]); end
            if (RESULTADO !== er[i]) begin bad++; $display("FAIL dir%0d_resultado got=%0d want=%0d", i, RESULTADO, er[i]); end
            if (PASOS_HECHOS !== ek[i]) begin bad++; $display("FAIL dir%0d_pasos got=%0d want=%0d", i, PASOS_HECHOS, ek[i]); end
            if (ERROR !== ee[i]) begin bad++; $display("FAIL dir%0d_error got=%0d want=%0d", i, ERROR, ee[i]); end
            if (enbs !== en[i]) begin bad++; $display("FAIL dir%0d_enb_cycles got=%0d want=%0d", i, enbs, en[i]); end
            if (busys !== el[i] - 1) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, busys, el[i] - 1); end
            tick();
        end
        res_exp = 4'd10;
    endtask

    task automatic test_start_while_busy;
        CMD_MODO = 2'b00; CMD_VALOR = 4'd3; CMD_PASOS = 4'd4; CMD_PARAR_RCO = 1'b0;
        START = 1'b1;
        tick();
        CMD_MODO = 2'b11; CMD_VALOR = 4'd1; CMD_PASOS = 4'd9;
        repeat (5) tick();
        START = 1'b0;
        tick();
        total += 4;
        if (DONE !== 1'b1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", DONE); end
        if (RESULTADO !== 4'd7) begin bad++; $display("FAIL busy_start_resultado got=%0d want=7", RESULTADO); end
        if (ERROR !== 1'b0) begin bad++; $display("FAIL busy_start_error got=%0d want=0", ERROR); end
        tick();
        if (DONE !== 1'b0) begin bad++; $display("FAIL busy_start_done_pulse got=%0d want=0", DONE); end
        res_exp = 4'd7;
    endtask

    task automatic test_back_to_back;
        int lat, enbs, busys;
        run_cmd(2'b10, 4'd15, 4'd4, 1'b0, lat, enbs, busys);
        total += 2;
        if (lat !== 7) begin bad++; $display("FAIL b2b_first_latency got=%0d want=7", lat); end
        if (RESULTADO !== 4'd3) begin bad++; $display("FAIL b2b_first_resultado got=%0d want=3", RESULTADO); end
        run_cmd(2'b00, 4'd5, 4'd2, 1'b1, lat, enbs, busys);
        total += 2;
        if (lat !== 5) begin bad++; $display("FAIL b2b_second_latency got=%0d want=5", lat); end
        if (RESULTADO !== 4'd7) begin bad++; $display("FAIL b2b_second_resultado got=%0d want=7", RESULTADO); end
        res_exp = 4'd7;
        tick();
    endtask

    task automatic test_random;
        logic [1:0] m;
        logic [3:0] v, p, r;
        logic       s, e;
        int         el, ek, en, lat, enbs, busys;
        for (int i = 0; i < 60; i++) begin
            m = 2'($urandom_range(0, 3));
            v = 4'($urandom);
            p = 4'($urandom);
            s = 1'($urandom_range(0, 1));
            ref_model(m, v, p, s, res_exp, el, ek, r, e, en);
            run_cmd(m, v, p, s, lat, enbs, busys);
            total += 5;
            if (lat !== el) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, el); end
            if (RESULTADO !== r) begin bad++; $display("FAIL rnd%0d_resultado got=%0d want=%0d", i, RESULTADO, r); end
            if (int'(PASOS_HECHOS) !== ek) begin bad++; $display("FAIL rnd%0d_pasos got=%0d want=%0d", i, PASOS_HECHOS, ek); end
            if (ERROR !== e) begin bad++; $display("FAIL rnd%0d_error got=%0d want=%0d", i, ERROR, e); end
            if (enbs !== en) begin bad++; $display("FAIL rnd%0d_enb_cycles got=%0d want=%0d", i, enbs, en); end
            res_exp = r;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_abort;
        int dones;
        CMD_MODO = 2'b00; CMD_VALOR = 4'd2; CMD_PASOS = 4'd12; CMD_PARAR_RCO = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        CMD_MODO = 2'b11;
        START = 1'b1;
        tick();
        START = 1'b0;
        total += 2;
        if (BUSY !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%0d want=1", BUSY); end
        if (ENB !== 1'b1) begin bad++; $display("FAIL abort_enb_before got=%0d want=1", ENB); end
        tick();
        RESET = 1'b1;
        START = 1'b1;
        tick();
        RESET = 1'b0;
        START = 1'b0;
        total++;
        if ({BUSY, DONE, ERROR, ENB, MODO, D, RESULTADO, PASOS_HECHOS} !== 18'd0) begin
            bad++;
            $display("FAIL abort_outputs got=%h want=0",
                     {BUSY, DONE, ERROR, ENB, MODO, D, RESULTADO, PASOS_HECHOS});
        end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            dones += int'(DONE) + int'(BUSY);
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        res_exp = 4'd0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/secuenciador_contador.md
# secuenciador_contador

Command sequencer for the 4-bit `contador` block (ENB/MODO/D in, Q/RCO out). On a START request it loads a start value into the counter via parallel load (MODO=11), then runs it for a programmed number of steps in one of the three counting modes. It can optionally stop early on the counter's RCO flag. When the sequence ends it reports the final count, the steps executed, and an error flag with a one-cycle DONE pulse. It sits between the test/control logic and the counter, and is the only driver of the counter's ENB, MODO and D.

## Interface
- No parameters; all widths are fixed to match the counter (4-bit data, 2-bit mode).
- CLK  in  1  single clock, rising edge; the counter shares it.
- RESET  in  1  synchronous, active-high reset; dominates every other input.
- START  in  1  command request, sampled only in IDLE; ignored while BUSY=1.
- CMD_MODO  in  2  run mode: 00 up +1, 01 down −1, 10 down −3; 11 is illegal.
- CMD_VALOR  in  4  start value loaded into the counter.
- CMD_PASOS  in  4  number of run steps, 0–15.
- CMD_PARAR_RCO  in  1  1 = stop the run early on RCO.
- Q  in  4  counter output.
- RCO  in  1  counter carry flag.
- ENB  out  1  counter enable.
- MODO  out  2  counter mode.
- D  out  4  counter parallel-load data.
- BUSY  out  1  high in LOAD, RUN and FIN.
- DONE  out  1  one-cycle completion pulse.
- ERROR  out  1  illegal-command flag; valid while DONE=1 and held until the next START.
- RESULTADO  out  4  Q captured at the end of the sequence.
- PASOS_HECHOS  out  4  number of run steps actually executed.

## Operation
- States: IDLE, LOAD, RUN, FIN.
- In IDLE, when START=1, the block latches CMD_MODO, CMD_VALOR, CMD_PASOS and CMD_PARAR_RCO.
  - Legal mode: next state is LOAD.
  - CMD_MODO=11: next state is FIN and the error flag is set. The counter is never enabled.
- LOAD: drives ENB=1, MODO=11, D=latched value. Always exactly 1 cycle.
  - Next state is RUN if latched steps > 0, otherwise FIN.
- RUN: drives ENB=1, MODO=latched mode, D=0.
  - An internal step counter increments on each enabled cycle.
  - Leaves to FIN after the cycle in which the step counter reaches the latched step count.
- Early stop applies when CMD_PARAR_RCO is latched, RCO=1, and the current cycle is not the first RUN cycle.
  - The first RUN cycle is excluded because RCO there still reflects the load.
  - On early stop, ENB=0 in that same cycle (combinational gating), the counter does not advance, and the next state is FIN.
- FIN: drives ENB=0, 1 cycle.
  - At its closing edge: RESULTADO<=Q (skipped on error), PASOS_HECHOS<=step counter, ERROR<=error flag, DONE<=1. Next state is IDLE.
- DONE is a registered pulse, high only during the first IDLE cycle after FIN. A START in that same cycle is accepted.
- Outputs in IDLE: ENB=0, MODO=00, D=0.
- ENB, MODO and D are decoded combinationally from the state and the latched command.
- Step arithmetic is 4-bit; the maximum of 15 steps never wraps. Counter values wrap modulo 16; that is the counter's own behaviour and needs no handling here.

## Timing
- Reset values: state=IDLE, ENB=0, MODO=00, D=0, BUSY=0, DONE=0, ERROR=0, RESULTADO=0, PASOS_HECHOS=0.
- RESET=1 mid-sequence returns the block to IDLE at the next edge.
  - ENB drops the cycle after that edge; the counter keeps its last Q.
  - No DONE pulse is produced for the aborted sequence.
- Legal command, no early stop: START seen in cycle 0, LOAD in cycle 1, RUN in cycles 2..N+1, FIN in cycle N+2, DONE in cycle N+3.
- N=0: DONE in cycle 3. Illegal command: FIN in cycle 1, DONE in cycle 2.
- Early stop after k steps: DONE is k+3 cycles after the START cycle plus 1 (the cycle of the gated RUN stop); PASOS_HECHOS=k.
- Relation to the counter, which is registered: Q and RCO in RUN cycle i reflect the edge at the end of cycle i−1. In the first RUN cycle Q=CMD_VALOR and RCO=1.
- RESULTADO, PASOS_HECHOS and ERROR change only at the FIN edge and hold until the next FIN.

## Test plan
- Reset, then START with CMD_MODO=00, CMD_VALOR=3, CMD_PASOS=4, CMD_PARAR_RCO=0 -> DONE in cycle 7, RESULTADO=7, PASOS_HECHOS=4, ERROR=0; BUSY high in cycles 1–6.
- START with CMD_MODO=10, CMD_VALOR=9, CMD_PASOS=2 -> counter shows 9, 6, 3; RESULTADO=3, PASOS_HECHOS=2.
- START with CMD_MODO=00, CMD_VALOR=13, CMD_PASOS=8, CMD_PARAR_RCO=1 -> Q goes 13, 14, 15, 0; run stops with ENB=0 in the cycle where RCO=1 and Q=0; RESULTADO=0, PASOS_HECHOS=3.
- START with CMD_MODO=11 -> ENB never asserted, DONE in cycle 2, ERROR=1, RESULTADO unchanged. Then START with CMD_MODO=01, CMD_VALOR=0, CMD_PASOS=1 -> RESULTADO=15, ERROR=0.
- START with CMD_PASOS=0, CMD_VALOR=10 -> only LOAD is issued; DONE in cycle 3, RESULTADO=10, PASOS_HECHOS=0.
- Mid-RUN pulse of RESET together with START, plus a START while BUSY -> returns to IDLE with all outputs zero and no DONE pulse; the START while BUSY is ignored.
